// File: rtl/speed_sequencer.sv
// Steps the clock divider through a small table of (speed, duration) entries.
// The speed output is never zero: rests and idle periods drive IDLE_SPEED with mute raised.
module speed_sequencer #(
    parameter int BASE_SPEED = 50000000,
    parameter int DEPTH      = 8,
    parameter int TICK_DIV   = BASE_SPEED / 1000,
    parameter int IDLE_SPEED = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  logic [19:0]                wr_speed,
    input  logic [15:0]                wr_dur,
    input  logic [$clog2(DEPTH):0]     num_steps,
    input  logic                       loop,
    input  logic                       start,
    input  logic                       stop,
    output logic [19:0]                speed,
    output logic                       mute,
    output logic [$clog2(DEPTH)-1:0]   step_idx,
    output logic                       busy,
    output logic                       done
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX  = PW'(TICK_DIV - 1);
    localparam logic [19:0]   IDLE_SPD = 20'(IDLE_SPEED);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_PLAY  = 2'd2;

    logic [19:0]   r_tab_speed [DEPTH];
    logic [15:0]   r_tab_dur   [DEPTH];
    logic [1:0]    r_state;
    logic [AW-1:0] r_last;
    logic          r_loop;
    logic [PW-1:0] r_presc;
    logic [15:0]   r_dur;

    logic          w_start_ok;
    logic [AW-1:0] w_last;
    logic          w_wrap;
    logic          w_expire;
    logic [AW-1:0] w_fetch_idx;
    logic [19:0]   w_ent_speed;
    logic [15:0]   w_ent_dur;
    logic [19:0]   w_ld_speed;
    logic          w_ld_mute;
    logic [15:0]   w_ld_dur;

    // The next entry is read as the state machine moves into FETCH, so its
    // speed is already visible during the FETCH cycle of that step.
    always_comb begin
        w_start_ok  = start && !stop && (num_steps != '0);
        w_last      = (num_steps > (AW+1)'(DEPTH)) ? AW'(DEPTH - 1)
                                                   : AW'(num_steps - 1'b1);
        w_wrap      = (r_presc == PRE_MAX);
        w_expire    = (r_state == S_PLAY) && w_wrap && (r_dur == 16'd1);
        w_fetch_idx = ((r_state == S_IDLE) || (step_idx == r_last)) ? '0
                                                                    : step_idx + 1'b1;
        w_ent_speed = r_tab_speed[w_fetch_idx];
        w_ent_dur   = r_tab_dur[w_fetch_idx];
        w_ld_speed  = (w_ent_speed == 20'd0) ? IDLE_SPD : w_ent_speed;
        w_ld_mute   = (w_ent_speed == 20'd0);
        w_ld_dur    = (w_ent_dur == 16'd0) ? 16'd1 : w_ent_dur;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_tab_speed[i] <= '0;
                r_tab_dur[i]   <= '0;
            end
        end else if (wr_en) begin
            r_tab_speed[wr_addr] <= wr_speed;
            r_tab_dur[wr_addr]   <= wr_dur;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_last   <= '0;
            r_loop   <= 1'b0;
            r_presc  <= '0;
            r_dur    <= '0;
            speed    <= IDLE_SPD;
            mute     <= 1'b1;
            step_idx <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start_ok) begin
                        r_last   <= w_last;
                        r_loop   <= loop;
                        busy     <= 1'b1;
                        step_idx <= w_fetch_idx;
                        speed    <= w_ld_speed;
                        mute     <= w_ld_mute;
                        r_dur    <= w_ld_dur;
                        r_presc  <= '0;
                        r_state  <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (stop) begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                        speed   <= IDLE_SPD;
                        mute    <= 1'b1;
                    end else begin
                        r_state <= S_PLAY;
                    end
                end
                S_PLAY: begin
                    if (stop) begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                        speed   <= IDLE_SPD;
                        mute    <= 1'b1;
                    end else begin
                        r_presc <= w_wrap ? '0 : r_presc + 1'b1;
                        if (w_wrap) begin
                            r_dur <= r_dur - 16'd1;
                        end
                        if (w_expire) begin
                            if ((step_idx != r_last) || r_loop) begin
                                step_idx <= w_fetch_idx;
                                speed    <= w_ld_speed;
                                mute     <= w_ld_mute;
                                r_dur    <= w_ld_dur;
                                r_presc  <= '0;
                                r_state  <= S_FETCH;
                            end else begin
                                r_state <= S_IDLE;
                                busy    <= 1'b0;
                                done    <= 1'b1;
                                speed   <= IDLE_SPD;
                                mute    <= 1'b1;
                            end
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_speed_sequencer.sv
// Scoreboard bench for speed_sequencer: each scenario queues the per-cycle output
// trace it expects, then compares it against the DUT one cycle at a time.
module tb_speed_sequencer;

    localparam int DEPTH = 8;
    localparam int TICK  = 4;

    logic        clk;
    logic        reset;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [19:0] wr_speed;
    logic [15:0] wr_dur;
    logic [3:0]  num_steps;
    logic        loop;
    logic        start;
    logic        stop;
    logic [19:0] speed;
    logic        mute;
    logic [2:0]  step_idx;
    logic        busy;
    logic        done;

    speed_sequencer #(
        .BASE_SPEED(4000),
        .DEPTH     (DEPTH),
        .TICK_DIV  (TICK),
        .IDLE_SPEED(1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_speed (wr_speed),
        .wr_dur   (wr_dur),
        .num_steps(num_steps),
        .loop     (loop),
        .start    (start),
        .stop     (stop),
        .speed    (speed),
        .mute     (mute),
        .step_idx (step_idx),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [19:0] spd;
        logic        mute;
        logic [2:0]  idx;
        logic        busy;
        logic        done;
    } obs_t;

    obs_t        expQ[$];
    obs_t        e;
    obs_t        o;
    int          nChecks;
    int          nErrors;
    logic [19:0] mSpd [DEPTH];
    logic [15:0] mDur [DEPTH];

    function automatic obs_t observe();
        obs_t r;
        r.spd  = speed;
        r.mute = mute;
        r.idx  = step_idx;
        r.busy = busy;
        r.done = done;
        return r;
    endfunction

    function automatic string show(input obs_t v);
        return $sformatf("spd=%0d mute=%0b idx=%0d busy=%0b done=%0b",
                         v.spd, v.mute, v.idx, v.busy, v.done);
    endfunction

    // Expected trace of one step: 1 + max(dur,1)*TICK cycles, optionally truncated.
    task automatic push_step(input int k, input int limit);
        obs_t x;
        int   cnt;
        x.spd  = (mSpd[k] == 20'd0) ? 20'd1 : mSpd[k];
        x.mute = (mSpd[k] == 20'd0);
        x.idx  = 3'(k);
        x.busy = 1'b1;
        x.done = 1'b0;
        cnt = 1 + ((mDur[k] == 16'd0) ? 1 : int'(mDur[k])) * TICK;
        if (limit > 0 && limit < cnt) cnt = limit;
        repeat (cnt) expQ.push_back(x);
    endtask

    task automatic push_idle(input int idx, input bit withDone, input int n);
        obs_t x;
        x.spd  = 20'd1;
        x.mute = 1'b1;
        x.idx  = 3'(idx);
        x.busy = 1'b0;
        x.done = 1'b1;
        if (withDone) expQ.push_back(x);
        x.done = 1'b0;
        repeat (n) expQ.push_back(x);
    endtask

    task automatic write_entry(input int a, input int s, input int d);
        @(negedge clk);
        wr_en    = 1'b1;
        wr_addr  = 3'(a);
        wr_speed = 20'(s);
        wr_dur   = 16'(d);
        mSpd[a]  = 20'(s);
        mDur[a]  = 16'(d);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        push_idle(0, 1'b0, 1);
        while (expQ.size() > 0) begin
            @(negedge clk);
            e = expQ.pop_front();
            o = observe();
            nChecks++;
            if (o !== e) begin
                nErrors++;
                $display("[TB] FAIL reset_state: got %s, expected %s", show(o), show(e));
            end
        end
        reset = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            mSpd[i] = '0;
            mDur[i] = '0;
        end
        push_idle(0, 1'b0, 10);
        while (expQ.size() > 0) begin
            @(negedge clk);
            e = expQ.pop_front();
            o = observe();
            nChecks++;
            if (o !== e) begin
                nErrors++;
                $display("[TB] FAIL reset_idle: got %s, expected %s", show(o), show(e));
            end
        end
    endtask

    task automatic test_basic();
        write_entry(0, 440, 2);
        write_entry(1, 880, 1);
        num_steps = 4'd2;
        loop      = 1'b0;
        push_step(0, 0);
        push_step(1, 0);
        push_idle(1, 1'b1, 2);
        pulse_start();
        while (expQ.size() > 0) begin
            @(negedge clk);
            e = expQ.pop_front();
            o = observe();
            nChecks++;
            if (o !== e) begin
                nErrors++;
                $display("[TB] FAIL basic: got %s, expected %s", show(o), show(e));
            end
        end
    endtask

    task automatic test_rest();
        write_entry(0, 440, 1);
        write_entry(1, 0, 0);
        write_entry(2, 300, 1);
        num_steps = 4'd3;
        loop      = 1'b0;
        for (int k = 0; k < 3; k++) push_step(k, 0);
        push_idle(2, 1'b1, 1);
        pulse_start();
        while (expQ.size() > 0) begin
            @(negedge clk);
            e = expQ.pop_front();
            o = observe();
            nChecks++;
            if (o !== e) begin
                nErrors++;
                $display("[TB] FAIL rest: got %s, expected %s", show(o), show(e));
            end
        end
    endtask

    task automatic test_loop_stop();
        write_entry(0, 500, 1);
        write_entry(1, 600, 1);
        num_steps = 4'd2;
        loop      = 1'b1;
        push_step(0, 0);
        push_step(1, 0);
        push_step(0, 0);
        push_step(1, 0);
        push_step(0, 2);
        pulse_start();
        while (expQ.size() > 0) begin
            @(negedge clk);
            e = expQ.pop_front();
            o = observe();
            nChecks++;
            if (o !== e) begin
                nErrors++;
                $display("[TB] FAIL loop: got %s, expected %s", show(o), show(e));
            end
        end
        stop = 1'b1;
        push_idle(0, 1'b0, 3);
        while (expQ.size() > 0) begin
            @(negedge clk);
            e = expQ.pop_front();
            o = observe();
            nChecks++;
            if (o !== e) begin
                nErrors++;
                $display("[TB] FAIL stop_play: got %s, expected %s", show(o), show(e));
            end
        end
        stop = 1'b0;
        loop = 1'b0;
    endtask

    task automatic test_rewrite();
        write_entry(0, 700, 2);
        write_entry(1, 800, 1);
        num_steps = 4'd2;
        loop      = 1'b1;
        push_step(0, 0);
        push_step(1, 0);
        mSpd[0] = 20'd1000;
        push_step(0, 0);
        pulse_start();
        repeat (2) begin
            @(negedge clk);
            e = expQ.pop_front();
            o = observe();
            nChecks++;
            if (o !== e) begin
                nErrors++;
                $display("[TB] FAIL rewrite_pre: got %s, expected %s", show(o), show(e));
            end
        end
        wr_en    = 1'b1;
        wr_addr  = 3'd0;
        wr_speed = 20'd1000;
        wr_dur   = 16'd2;
        while (expQ.size() > 0) begin
            @(negedge clk);
            wr_en = 1'b0;
            e = expQ.pop_front();
            o = observe();
            nChecks++;
            if (o !== e) begin
                nErrors++;
                $display("[TB] FAIL rewrite: got %s, expected %s", show(o), show(e));
            end
        end
        stop = 1'b1;
        push_idle(0, 1'b0, 2);
        while (expQ.size() > 0) begin
            @(negedge clk);
            e = expQ.pop_front();
            o = observe();
            nChecks++;
            if (o !== e) begin
                nErrors++;
                $display("[TB] FAIL rewrite_stop: got %s, expected %s", show(o), show(e));
            end
        end
        stop = 1'b0;
        loop = 1'b0;
    endtask

    task automatic test_start_controls();
        // start together with stop, then start with an empty step count: both ignored
        num_steps = 4'd2;
        @(negedge clk);
        start = 1'b1;
        stop  = 1'b1;
        push_idle(0, 1'b0, 3);
        while (expQ.size() > 0) begin
            @(negedge clk);
            e = expQ.pop_front();
            o = observe();
            nChecks++;
            if (o !== e) begin
                nErrors++;
                $display("[TB] FAIL start_stop: got %s, expected %s", show(o), show(e));
            end
        end
        stop      = 1'b0;
        num_steps = 4'd0;
        push_idle(0, 1'b0, 3);
        while (expQ.size() > 0) begin
            @(negedge clk);
            e = expQ.pop_front();
            o = observe();
            nChecks++;
            if (o !== e) begin
                nErrors++;
                $display("[TB] FAIL zero_steps: got %s, expected %s", show(o), show(e));
            end
        end
        start = 1'b0;
    endtask

    task automatic test_clamp();
        for (int i = 0; i < DEPTH; i++) write_entry(i, 100 * (i + 1), 1);
        num_steps = 4'd12;
        loop      = 1'b0;
        for (int k = 0; k < DEPTH; k++) push_step(k, 0);
        push_idle(DEPTH - 1, 1'b1, 1);
        pulse_start();
        while (expQ.size() > 0) begin
            @(negedge clk);
            e = expQ.pop_front();
            o = observe();
            nChecks++;
            if (o !== e) begin
                nErrors++;
                $display("[TB] FAIL clamp: got %s, expected %s", show(o), show(e));
            end
        end
    endtask

    task automatic test_back_to_back();
        write_entry(0, 250, 1);
        num_steps = 4'd1;
        loop      = 1'b0;
        push_step(0, 0);
        push_idle(0, 1'b1, 0);
        push_step(0, 0);
        @(negedge clk);
        start = 1'b1;
        while (expQ.size() > 0) begin
            @(negedge clk);
            e = expQ.pop_front();
            o = observe();
            nChecks++;
            if (o !== e) begin
                nErrors++;
                $display("[TB] FAIL back_to_back: got %s, expected %s", show(o), show(e));
            end
        end
        start = 1'b0;
        push_idle(0, 1'b1, 2);
        while (expQ.size() > 0) begin
            @(negedge clk);
            e = expQ.pop_front();
            o = observe();
            nChecks++;
            if (o !== e) begin
                nErrors++;
                $display("[TB] FAIL back_to_back_end: got %s, expected %s", show(o), show(e));
            end
        end
    endtask

    initial begin
        nChecks   = 0;
        nErrors   = 0;
        reset     = 1'b1;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_speed  = '0;
        wr_dur    = '0;
        num_steps = '0;
        loop      = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        test_reset();
        test_basic();
        test_rest();
        test_loop_stop();
        test_rewrite();
        test_start_controls();
        test_clamp();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
